dla_filter_bias_scale_scratchpad_writer: RTL

DLA_FILTER_BIAS_SCALE_SCRATCHPAD_WRITER -- requirements
Module: dla_filter_bias_scale_scratchpad_writer

---
 rtl/dla_filter_bias_scale_scratchpad_writer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/dla_filter_bias_scale_scratchpad_writer.sv
// Steers a DMA stream of filter words (round-robin across the filter scratchpad ports)
// followed by bias/scale words into scratchpad write requests, one layer per config.
module dla_filter_bias_scale_scratchpad_writer #(
  parameter int unsigned DATA_WIDTH  = 256,
  parameter int unsigned NUM_PORTS   = 4,
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned COUNT_WIDTH = 16,
  localparam int unsigned PORT_WIDTH = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                   clk,
  input  logic                   i_aresetn,
  input  logic                   i_config_valid,
  input  logic [COUNT_WIDTH-1:0] i_num_filter_words,
  input  logic [COUNT_WIDTH-1:0] i_num_bias_scale_words,
  output logic                   o_config_ready,
  input  logic                   i_data_valid,
  input  logic [DATA_WIDTH-1:0]  i_data,
  output logic                   o_data_ready,
  output logic                   o_wr_valid,
  input  logic                   i_wr_ready,
  output logic                   o_wr_is_filter,
  output logic [PORT_WIDTH-1:0]  o_wr_port,
  output logic [ADDR_WIDTH-1:0]  o_wr_addr,
  output logic [DATA_WIDTH-1:0]  o_wr_data,
  output logic                   o_done
);

  typedef enum logic [1:0] {IDLE, FILTER, BIAS, FLUSH} state_t;

  state_t                 state;
  state_t                 state_next;
  logic [COUNT_WIDTH-1:0] filter_left;
  logic [COUNT_WIDTH-1:0] bias_left;
  logic [PORT_WIDTH-1:0]  port_cnt;
  logic [ADDR_WIDTH-1:0]  addr_cnt;
  logic                   cfg_fire;
  logic                   data_fire;
  logic                   drained;
  logic                   port_wrap;
  logic                   last_filter;
  logic                   last_bias;
  logic                   done_next;

  assign o_config_ready = (state == IDLE);
  assign drained        = !o_wr_valid || i_wr_ready;
  assign o_data_ready   = ((state == FILTER) || (state == BIAS)) && drained;
  assign cfg_fire       = i_config_valid && o_config_ready;
  assign data_fire      = i_data_valid && o_data_ready;
  assign port_wrap      = (port_cnt == PORT_WIDTH'(NUM_PORTS - 1));
  assign last_filter    = (filter_left == COUNT_WIDTH'(1));
  assign last_bias      = (bias_left == COUNT_WIDTH'(1));

  // State register
  always_ff @(posedge clk or negedge i_aresetn) begin
    if (!i_aresetn) state <= IDLE;
    else            state <= state_next;
  end

  // Next-state and done decode
  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_fire) begin
          if (i_num_filter_words != '0)          state_next = FILTER;
          else if (i_num_bias_scale_words != '0) state_next = BIAS;
          else                                   state_next = FLUSH;
        end
      end
      FILTER: begin
        if (data_fire && last_filter) state_next = (bias_left != '0) ? BIAS : FLUSH;
      end
      BIAS: begin
        if (data_fire && last_bias) state_next = FLUSH;
      end
      FLUSH: begin
        if (drained) begin
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Remaining-word counts and port/address walkers; bias addresses restart at 0
  always_ff @(posedge clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      filter_left <= '0;
      bias_left   <= '0;
      port_cnt    <= '0;
      addr_cnt    <= '0;
    end else if (cfg_fire) begin
      filter_left <= i_num_filter_words;
      bias_left   <= i_num_bias_scale_words;
      port_cnt    <= '0;
      addr_cnt    <= '0;
    end else if (data_fire) begin
      if (state == FILTER) begin
        filter_left <= filter_left - COUNT_WIDTH'(1);
        if (last_filter) begin
          port_cnt <= '0;
          addr_cnt <= '0;
        end else begin
          port_cnt <= port_wrap ? '0 : port_cnt + PORT_WIDTH'(1);
          if (port_wrap) addr_cnt <= addr_cnt + ADDR_WIDTH'(1);
        end
      end else begin
        bias_left <= bias_left - COUNT_WIDTH'(1);
        addr_cnt  <= addr_cnt + ADDR_WIDTH'(1);
      end
    end
  end

  // Write request register: loads on stream handshake, holds until accepted
  always_ff @(posedge clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      o_wr_valid     <= 1'b0;
      o_wr_is_filter <= 1'b0;
      o_wr_port      <= '0;
      o_wr_addr      <= '0;
      o_wr_data      <= '0;
    end else if (data_fire) begin
      o_wr_valid     <= 1'b1;
      o_wr_is_filter <= (state == FILTER);
      o_wr_port      <= (state == FILTER) ? port_cnt : '0;
      o_wr_addr      <= addr_cnt;
      o_wr_data      <= i_data;
    end else if (i_wr_ready) begin
      o_wr_valid     <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge i_aresetn) begin
    if (!i_aresetn) o_done <= 1'b0;
    else            o_done <= done_next;
  end

endmodule
